// File: rtl/line_mem_responder.sv
// Memory-side line-fill responder: one request in, one tagged 8-beat line out
// after a fixed wait, served from a preloadable word store.
module line_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_ADDR_BITS  = 10,
  parameter int LATENCY        = 4,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_bus_reqcyc,
  output logic                      m_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  output logic                      m_bus_respcyc,
  input  logic                      m_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
  input  logic                      load_en,
  input  logic [MEM_ADDR_BITS-1:0]  load_addr,
  input  logic [BUS_DATA_WIDTH-1:0] load_data
);

  localparam int BW  = $clog2(BEATS);
  localparam int LBW = MEM_ADDR_BITS - BW;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [BUS_DATA_WIDTH-1:0] r_mem [2**MEM_ADDR_BITS];
  logic [BUS_DATA_WIDTH-1:0] r_buf [BEATS];

  logic [LBW-1:0]            r_base;
  logic [BUS_TAG_WIDTH-1:0]  r_tag;
  logic [CW-1:0]             r_cnt;
  logic [BW-1:0]             r_beat;
  logic                      r_reqack;
  logic                      r_respcyc;
  logic [BUS_DATA_WIDTH-1:0] r_resp;
  logic [BUS_TAG_WIDTH-1:0]  r_resptag;

  logic          w_capture;
  logic          w_snap;
  logic          w_fire;
  logic          w_last;
  logic [BW-1:0] w_beat_nxt;
  logic          w_unused;

  // Offset bits and address bits above the store alias away.
  assign w_unused = ^{m_bus_req[BUS_DATA_WIDTH-1:MEM_ADDR_BITS+3],
                      m_bus_req[5:0]};

  assign w_capture  = (r_state == S_IDLE) && m_bus_reqcyc;
  assign w_snap     = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_fire     = (r_state == S_SEND) && m_bus_respack;
  assign w_last     = (r_beat == BW'(BEATS - 1));
  assign w_beat_nxt = r_beat + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (m_bus_reqcyc) w_next = S_ACK;
      S_ACK:   w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_SEND;
      S_SEND:  if (m_bus_respack && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  // Snapshot reads the pre-write store, so a same-edge load is not seen.
  always_ff @(posedge clk) begin
    if (w_snap) begin
      for (int k = 0; k < BEATS; k++) begin
        r_buf[k] <= r_mem[{r_base, BW'(k)}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reqack  <= 1'b0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
      r_base    <= '0;
      r_tag     <= '0;
    end else begin
      r_reqack <= w_capture;
      if (w_capture) begin
        r_base <= m_bus_req[MEM_ADDR_BITS+2:6];
        r_tag  <= m_bus_reqtag;
      end
      if (r_state == S_ACK) begin
        r_cnt <= CW'(LATENCY - 1);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_snap) begin
        r_respcyc <= 1'b1;
        r_resp    <= r_mem[{r_base, {BW{1'b0}}}];
        r_resptag <= r_tag;
        r_beat    <= '0;
      end else if (w_fire) begin
        if (w_last) begin
          r_respcyc <= 1'b0;
        end else begin
          r_beat <= w_beat_nxt;
          r_resp <= r_buf[w_beat_nxt];
        end
      end
    end
  end

  assign m_bus_reqack  = r_reqack;
  assign m_bus_respcyc = r_respcyc;
  assign m_bus_resp    = r_resp;
  assign m_bus_resptag = r_resptag;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: request-timeline model checked every cycle
// plus directed scenarios with literal expectations.
module tb_line_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_bus_reqcyc;
  logic        m_bus_reqack;
  logic [63:0] m_bus_req;
  logic [12:0] m_bus_reqtag;
  logic        m_bus_respcyc;
  logic        m_bus_respack;
  logic [63:0] m_bus_resp;
  logic [12:0] m_bus_resptag;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [63:0] load_data;

  always #5 clk = ~clk;

  line_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_bus_reqcyc  (m_bus_reqcyc),
    .m_bus_reqack  (m_bus_reqack),
    .m_bus_req     (m_bus_req),
    .m_bus_reqtag  (m_bus_reqtag),
    .m_bus_respcyc (m_bus_respcyc),
    .m_bus_respack (m_bus_respack),
    .m_bus_resp    (m_bus_resp),
    .m_bus_resptag (m_bus_resptag),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Model: a request is a timeline measured from its capture edge.
  logic [63:0] m_mem [1024];
  logic [63:0] m_line [8];
  bit          started = 0;
  bit          m_act = 0;
  bit          m_send = 0;
  int          m_age = 0;
  int          m_idx = 0;
  int          m_base = 0;
  logic [12:0] m_tag = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1;
      m_act   = 0;
      m_send  = 0;
    end else if (!m_act) begin
      if (m_bus_reqcyc) begin
        m_act  = 1;
        m_send = 0;
        m_age  = 0;
        m_tag  = m_bus_reqtag;
        m_base = int'(m_bus_req[12:6]);
      end
    end else if (!m_send) begin
      m_age++;
      if (m_age == LAT + 1) begin
        for (int k = 0; k < 8; k++) m_line[k] = m_mem[m_base * 8 + k];
        m_send = 1;
        m_idx  = 0;
      end
    end else if (m_bus_respack) begin
      m_idx++;
      if (m_idx == 8) begin
        m_act  = 0;
        m_send = 0;
      end
    end
    if (load_en) m_mem[load_addr] = load_data;
  end

  logic [63:0] got_data [$];
  logic [12:0] got_tag [$];
  int          got_cyc [$];
  int          ack_q [$];
  int          rstart_q [$];
  logic        prev_cyc = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("reqack", m_bus_reqack, m_act && !m_send && m_age == 0);
      chk("respcyc", m_bus_respcyc, m_act && m_send);
      if (m_act && m_send) begin
        chk("resp", m_bus_resp, m_line[m_idx]);
        chk("resptag", m_bus_resptag, m_tag);
      end
      if (m_bus_reqack) ack_q.push_back(cyc);
      if (m_bus_respcyc && !prev_cyc) rstart_q.push_back(cyc);
      prev_cyc = m_bus_respcyc;
      if (m_bus_respcyc && m_bus_respack) begin
        got_data.push_back(m_bus_resp);
        got_tag.push_back(m_bus_resptag);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [63:0] d);
    load_en   = 1'b1;
    load_addr = 10'(a);
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_ack(input int n);
    int t = 0;
    while (ack_q.size() < n && t < 60) begin
      tick();
      t++;
    end
    if (ack_q.size() < n) begin
      n_tot++;
      $display("FAIL ack_timeout: got %0d acks required %0d", ack_q.size(), n);
    end
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_data.size() < n && t < 200) begin
      tick();
      t++;
    end
    if (got_data.size() < n) begin
      n_tot++;
      $display("FAIL beat_timeout: got %0d beats required %0d",
               got_data.size(), n);
    end
  endtask

  task automatic start_req(input logic [63:0] a, input logic [12:0] t,
                           input bit hold);
    int n;
    n = ack_q.size() + 1;
    m_bus_req    = a;
    m_bus_reqtag = t;
    m_bus_reqcyc = 1'b1;
    wait_ack(n);
    if (!hold) m_bus_reqcyc = 1'b0;
  endtask

  task automatic chk_line(input string nm, input int first);
    for (int i = 0; i < 8; i++)
      chk(nm, got_data[first + i], 64'h1000 + 64'(i));
  endtask

  int c0;
  int na;

  initial begin
    reset         = 1'b1;
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b1;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reqack", m_bus_reqack, 0);
    chk("rst_respcyc", m_bus_respcyc, 0);
    chk("rst_resp", m_bus_resp, 0);
    chk("rst_resptag", m_bus_resptag, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) load(16'h40 + i, 64'h1000 + 64'(i));
    tick();

    // Basic line fill and its timing
    got_data.delete();
    c0 = cyc;
    start_req(64'h200, 13'h05, 0);
    chk("t1_ack_cycle", ack_q[$], c0 + 1);
    wait_got(8);
    chk("t1_first_beat_cycle", rstart_q[$], c0 + 1 + LAT + 1);
    chk_line("t1_beat", 0);
    chk("t1_tag0", got_tag[0], 13'h05);
    chk("t1_tag7", got_tag[7], 13'h05);
    repeat (3) tick();

    // Three-cycle stall on beat 3
    got_data.delete();
    start_req(64'h200, 13'h05, 0);
    wait_got(3);
    m_bus_respack = 1'b0;
    @(negedge clk);
    chk("t2_stall_data", m_bus_resp, 64'h1003);
    chk("t2_stall_cyc", m_bus_respcyc, 1);
    repeat (3) tick();
    m_bus_respack = 1'b1;
    wait_got(8);
    repeat (4) tick();
    chk("t2_count", got_data.size(), 8);
    chk_line("t2_beat", 0);

    // Unaligned and aliased addresses
    got_data.delete();
    start_req(64'h23F, 13'h11, 0);
    wait_got(8);
    chk_line("t3_unaligned", 0);
    repeat (2) tick();
    got_data.delete();
    start_req(64'h10200, 13'h12, 0);
    wait_got(8);
    chk_line("t3_alias", 0);
    repeat (2) tick();

    // Back-to-back request held high
    got_data.delete();
    got_tag.delete();
    got_cyc.delete();
    na = ack_q.size();
    start_req(64'h200, 13'h01, 1);
    m_bus_reqtag = 13'h02;
    wait_got(8);
    wait_ack(na + 2);
    m_bus_reqcyc = 1'b0;
    wait_got(16);
    repeat (3) tick();
    chk("t4_ack_count", ack_q.size() - na, 2);
    chk("t4_second_ack", ack_q[na + 1], got_cyc[7] + 2);
    chk("t4_tag_a", got_tag[0], 13'h01);
    chk("t4_tag_a7", got_tag[7], 13'h01);
    chk("t4_tag_b", got_tag[8], 13'h02);
    chk("t4_tag_b7", got_tag[15], 13'h02);
    chk_line("t4_line_b", 8);

    // Loads during WAIT, on the snapshot edge, and during SEND
    got_data.delete();
    start_req(64'h200, 13'h07, 0);
    load(16'h41, 64'hDEAD);
    tick();
    tick();
    load(16'h42, 64'hBEEF);
    wait_got(8);
    chk("t5_wait_load", got_data[1], 64'hDEAD);
    chk("t5_snap_edge_load", got_data[2], 64'h1002);
    repeat (2) tick();
    load(16'h41, 64'h1001);
    load(16'h42, 64'h1002);
    got_data.delete();
    start_req(64'h200, 13'h08, 0);
    wait_got(1);
    load(16'h41, 64'hDEAD);
    wait_got(8);
    chk("t5_send_load", got_data[1], 64'h1001);
    repeat (2) tick();
    load(16'h41, 64'h1001);

    // Reset in the middle of SEND
    got_data.delete();
    start_req(64'h200, 13'h09, 0);
    wait_got(4);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_rst_respcyc", m_bus_respcyc, 0);
    chk("t6_rst_reqack", m_bus_reqack, 0);
    chk("t6_rst_resp", m_bus_resp, 0);
    tick();
    reset = 1'b0;
    tick();
    got_data.delete();
    start_req(64'h200, 13'h0A, 0);
    wait_got(8);
    repeat (3) tick();
    chk("t6_count", got_data.size(), 8);
    chk_line("t6_beat", 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
